fsm_out_framer: RTL and testbench
=================================

# fsm_out_framer

Parametrised output framer for one switch egress port; successor to the fixed 8-bit egress FSM. Pulls a packet from a first-word-fall-through (FWFT) port FIFO and emits it on the port as SOF, optional address, payload and delimiter. Adds per-byte downstream backpressure, FIFO-empty stalls mid-packet, a maximum-length guard with truncation and drain, and status outputs. Sits between the port FIFO and the port output pins.

## Interface
- W_WIDTH, 8: data and address width.
- SOF_BYTE, 8'hFF (W_WIDTH wide): start-of-frame word emitted first.
- DELIMITER, 8'h55 (W_WIDTH wide): end-of-packet word, stored in the FIFO as the last word of each packet.
- MAX_PKT_LEN, 64: maximum number of non-delimiter payload words per packet; must be ≥1.
- ADDR_EN, 1: when 1, emit port_addr after SOF; when 0, skip the ADDR state.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- port_addr  in  W_WIDTH  port address, sampled in the ADDR state.
- fifo_data  in  W_WIDTH  FWFT head of the port FIFO; valid when fifo_empty=0.
- fifo_empty  in  1  port FIFO empty.
- port_rd  in  1  downstream ready; a word may be emitted only in a cycle where it is 1.
- rd_en  out  1  combinational FIFO pop; pops the head at the rising edge.
- port_out  out  W_WIDTH  registered output word; 0 whenever port_valid=0.
- port_valid  out  1  registered; port_out carries a frame word.
- pkt_done  out  1  registered 1-cycle pulse, coincident with an emitted delimiter after normal termination.
- err_trunc  out  1  registered 1-cycle pulse, coincident with an inserted delimiter after truncation.
- busy  out  1  combinational; state != IDLE.

## Operation
- States: IDLE, SOF, ADDR, PAYLOAD, DRAIN.
- IDLE: nothing is emitted. Go to SOF when port_rd=1 and fifo_empty=0.
- SOF: if port_rd=1, emit SOF_BYTE, then go to ADDR (ADDR_EN=1) or PAYLOAD (ADDR_EN=0). Otherwise hold.
- ADDR: if port_rd=1, emit port_addr as sampled this cycle, then go to PAYLOAD. Otherwise hold.
- PAYLOAD: a word moves when port_rd=1 and fifo_empty=0. Then rd_en=1 and fifo_data is emitted unchanged; a word equal to SOF_BYTE gets no special handling.
  - If the popped word equals DELIMITER: assert pkt_done with it, clear len_cnt, go to IDLE.
  - Otherwise increment len_cnt.
- PAYLOAD stall: if port_rd=0 or fifo_empty=1, rd_en=0, port_valid<=0, port_out<=0, and state and len_cnt hold.
- Length guard: len_cnt is $clog2(MAX_PKT_LEN+1) bits and counts non-delimiter payload words.
  - When len_cnt==MAX_PKT_LEN in PAYLOAD with port_rd=1 and fifo_empty=0:
    - If the head is DELIMITER, terminate normally as above.
    - Otherwise do not pop. Emit DELIMITER (inserted), assert err_trunc, clear len_cnt, go to DRAIN.
- DRAIN: port_valid=0. rd_en=!fifo_empty, independent of port_rd. Popped words are discarded. On popping DELIMITER, go to IDLE.
- rd_en is 0 in IDLE, SOF and ADDR.

## Timing
- Reset values: state=IDLE, len_cnt=0, port_out=0, port_valid=0, pkt_done=0, err_trunc=0. Hence rd_en=0 and busy=0.
- Reset mid-packet: the frame is abandoned immediately and no delimiter is emitted. FIFO contents are not touched by the reset.
- Output latency: a word decided in cycle N appears on port_out/port_valid in cycle N+1.
- Request seen in IDLE at cycle 0, port_rd held high, FIFO never empty:
  - SOF at cycle 2.
  - Address at cycle 3.
  - First payload word at cycle 4, popped with rd_en=1 in cycle 3.
  - With ADDR_EN=0, the first payload word appears at cycle 3.
- One word per cycle at full rate; port_valid is contiguous from SOF to delimiter when nothing stalls.
- Inter-packet gap: at least one IDLE cycle. After the delimiter edge the next SOF appears 2 cycles later at the earliest.
- Simultaneous port_rd=0 and fifo_empty=1: stall, no pop.
- fifo_empty=1 in IDLE: stay in IDLE; no SOF is emitted without data.

## Test plan
- Basic frame: port_addr=0x03, FIFO AA BB 55 -> port_out FF,03,AA,BB,55 on consecutive valid cycles; rd_en high 3 cycles; pkt_done with 55.
- Backpressure: same packet, port_rd=0 for 2 cycles after the 03 -> port_valid=0 and port_out=0 for 2 cycles, then AA,BB,55; no pop during the gap.
- Empty stall: FIFO delivers AA, goes empty 3 cycles, then BB 55 -> AA, 3 invalid cycles, BB, 55; state stays PAYLOAD.
- Truncation: MAX_PKT_LEN=4, FIFO 01..06 55 -> FF,addr,01,02,03,04,55 with err_trunc; 05,06,55 drained with port_valid=0; IDLE afterwards, FIFO empty.
- Back-to-back, ADDR_EN=0: FIFO AA 55 CC 55 -> FF,AA,55, one idle cycle, FF,CC,55; two pkt_done pulses.
- Reset mid-packet: rst pulsed after AA of a 4-word packet -> all outputs 0 the next cycle; remaining FIFO words untouched.

Source files
------------

// File: rtl/fsm_out_framer.sv
// Egress framer: pulls packets from an FWFT port FIFO and emits SOF, optional
// address, payload and delimiter, with backpressure, stalls and a length guard.
module fsm_out_framer #(
    parameter int                 W_WIDTH     = 8,
    parameter logic [W_WIDTH-1:0] SOF_BYTE    = W_WIDTH'(8'hFF),
    parameter logic [W_WIDTH-1:0] DELIMITER   = W_WIDTH'(8'h55),
    parameter int                 MAX_PKT_LEN = 64,
    parameter bit                 ADDR_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_WIDTH-1:0] port_addr,
    input  logic [W_WIDTH-1:0] fifo_data,
    input  logic               fifo_empty,
    input  logic               port_rd,
    output logic               rd_en,
    output logic [W_WIDTH-1:0] port_out,
    output logic               port_valid,
    output logic               pkt_done,
    output logic               err_trunc,
    output logic               busy
);

    localparam int               LEN_W   = $clog2(MAX_PKT_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_LEN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOF     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t           state_r;
    logic [LEN_W-1:0] len_cnt_r;
    logic             word_ok_s;
    logic             head_is_delim_s;
    logic             at_max_s;
    logic             pop_s;

    assign word_ok_s       = port_rd && !fifo_empty;
    assign head_is_delim_s = (fifo_data == DELIMITER);
    assign at_max_s        = (len_cnt_r == LEN_MAX);
    assign busy            = (state_r != ST_IDLE);

    // FIFO pop decision; at the length limit a non-delimiter head stays in the FIFO
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_PAYLOAD: begin
                if (word_ok_s && (head_is_delim_s || !at_max_s)) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_DRAIN: pop_s = !fifo_empty;
            default:  pop_s = 1'b0;
        endcase
    end

    // Reset must leave the FIFO untouched, so the pop is suppressed while rst is high
    always_comb begin
        if (rst) begin
            rd_en = 1'b0;
        end else begin
            rd_en = pop_s;
        end
    end

    // Frame state machine with registered output word and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            len_cnt_r  <= '0;
            port_out   <= '0;
            port_valid <= 1'b0;
            pkt_done   <= 1'b0;
            err_trunc  <= 1'b0;
        end else begin
            port_out   <= '0;
            port_valid <= 1'b0;
            pkt_done   <= 1'b0;
            err_trunc  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (word_ok_s) begin
                        state_r <= ST_SOF;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SOF: begin
                    if (port_rd) begin
                        port_out   <= SOF_BYTE;
                        port_valid <= 1'b1;
                        if (ADDR_EN) begin
                            state_r <= ST_ADDR;
                        end else begin
                            state_r <= ST_PAYLOAD;
                        end
                    end else begin
                        state_r <= ST_SOF;
                    end
                end
                ST_ADDR: begin
                    if (port_rd) begin
                        port_out   <= port_addr;
                        port_valid <= 1'b1;
                        state_r    <= ST_PAYLOAD;
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end
                ST_PAYLOAD: begin
                    if (word_ok_s) begin
                        port_valid <= 1'b1;
                        if (head_is_delim_s) begin
                            port_out  <= fifo_data;
                            pkt_done  <= 1'b1;
                            len_cnt_r <= '0;
                            state_r   <= ST_IDLE;
                        end else if (at_max_s) begin
                            // Over-long packet: close the frame here and discard the rest
                            port_out  <= DELIMITER;
                            err_trunc <= 1'b1;
                            len_cnt_r <= '0;
                            state_r   <= ST_DRAIN;
                        end else begin
                            port_out  <= fifo_data;
                            len_cnt_r <= len_cnt_r + LEN_W'(1);
                        end
                    end else begin
                        state_r <= ST_PAYLOAD;
                    end
                end
                ST_DRAIN: begin
                    if (!fifo_empty && head_is_delim_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    len_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_out_framer.sv
// Bench for fsm_out_framer: directed frames with literal expectations plus a
// randomized run checked against a packet-level stream model.
module tb_fsm_out_framer;

    localparam int         MAXL  = 4;
    localparam logic [7:0] DELIM = 8'h55;
    localparam logic [7:0] SOFB  = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       port_rd;
    logic [7:0] port_addr;
    logic [7:0] fifo_data, fifo_data_b;
    logic       fifo_empty, fifo_empty_b;
    logic       rd_en, port_valid, pkt_done, err_trunc, busy;
    logic [7:0] port_out;
    logic       rd_en_b, port_valid_b, pkt_done_b, err_trunc_b, busy_b;
    logic [7:0] port_out_b;

    always #5 clk = ~clk;

    fsm_out_framer #(.W_WIDTH(8), .SOF_BYTE(SOFB), .DELIMITER(DELIM),
                     .MAX_PKT_LEN(MAXL), .ADDR_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .port_addr(port_addr), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .port_rd(port_rd), .rd_en(rd_en),
        .port_out(port_out), .port_valid(port_valid), .pkt_done(pkt_done),
        .err_trunc(err_trunc), .busy(busy));

    fsm_out_framer #(.W_WIDTH(8), .SOF_BYTE(SOFB), .DELIMITER(DELIM),
                     .MAX_PKT_LEN(MAXL), .ADDR_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .port_addr(port_addr), .fifo_data(fifo_data_b),
        .fifo_empty(fifo_empty_b), .port_rd(port_rd), .rd_en(rd_en_b),
        .port_out(port_out_b), .port_valid(port_valid_b), .pkt_done(pkt_done_b),
        .err_trunc(err_trunc_b), .busy(busy_b));

    typedef struct packed { logic [7:0] w; logic drop; } fword_t;
    typedef struct packed { logic [7:0] w; logic d; logic t; } exp_t;

    fword_t     fifo_q[$];
    fword_t     src_q[$];
    logic [7:0] fifo_b[$];
    exp_t       exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int n_pops_b = 0;
    int pkt_idx  = 0;
    bit model_en = 1'b0;
    bit pop_v, pop_b_v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic put(input fword_t f, input bit to_src);
        if (to_src) src_q.push_back(f);
        else        fifo_q.push_back(f);
    endtask

    // Expected frame: SOF, address, up to MAXL words, then a delimiter flagged
    // as normal end or truncation; words past the limit are silently drained.
    task automatic start_pkt();
        pkt_idx = 0;
        exp_q.push_back('{w: SOFB, d: 1'b0, t: 1'b0});
        exp_q.push_back('{w: port_addr, d: 1'b0, t: 1'b0});
    endtask

    task automatic add_word(input logic [7:0] w, input bit to_src);
        put('{w: w, drop: (pkt_idx >= MAXL)}, to_src);
        if (pkt_idx < MAXL) exp_q.push_back('{w: w, d: 1'b0, t: 1'b0});
        pkt_idx++;
    endtask

    task automatic end_pkt(input bit to_src);
        put('{w: DELIM, drop: (pkt_idx > MAXL)}, to_src);
        exp_q.push_back('{w: DELIM, d: (pkt_idx <= MAXL), t: (pkt_idx > MAXL)});
    endtask

    task automatic model_check(input bit popped, input fword_t pw, input logic rd);
        exp_t e;
        if (popped) begin
            if (!pw.drop) chk("pop_emit", 32'({port_valid, port_out, rd}), 32'({1'b1, pw.w, 1'b1}));
            else          chk("drain_silent", 32'(port_valid), 32'd0);
        end
        if (port_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL extra_word: actual=0x%0h required=none", port_out);
            end else begin
                e = exp_q.pop_front();
                chk("stream", 32'({port_out, pkt_done, err_trunc, rd}), 32'({e.w, e.d, e.t, 1'b1}));
            end
        end else begin
            chk("idle_zero", 32'({port_out, pkt_done, err_trunc}), 32'd0);
        end
    endtask

    // One clock: drive inputs, note pops, advance, pop models, check at negedge
    task automatic cycle(input logic rd, input logic fe_force);
        fword_t pw;
        bit     got_a;
        got_a        = 1'b0;
        pw           = '0;
        port_rd      = rd;
        fifo_empty   = (fifo_q.size() == 0) || fe_force;
        fifo_data    = (fifo_q.size() != 0) ? fifo_q[0].w : 8'h00;
        fifo_empty_b = (fifo_b.size() == 0);
        fifo_data_b  = (fifo_b.size() != 0) ? fifo_b[0] : 8'h00;
        #1;
        pop_v   = rd_en;
        pop_b_v = rd_en_b;
        chk("pop_when_empty", 32'({rd_en && fifo_empty, rd_en_b && fifo_empty_b}), 32'd0);
        @(posedge clk);
        if (pop_v && fifo_q.size() != 0) begin
            pw    = fifo_q.pop_front();
            got_a = 1'b1;
            n_pops++;
        end
        if (pop_b_v && fifo_b.size() != 0) begin
            void'(fifo_b.pop_front());
            n_pops_b++;
        end
        @(negedge clk);
        if (model_en) model_check(got_a, pw, rd);
    endtask

    task automatic dcyc(input string nm, input logic rd, input logic fe, input logic v,
                        input logic [7:0] o, input logic d, input logic t, input logic p);
        cycle(rd, fe);
        chk(nm, 32'({port_valid, port_out, pkt_done, err_trunc, pop_v}), 32'({v, o, d, t, p}));
    endtask

    task automatic bcyc(input string nm, input logic v, input logic [7:0] o,
                        input logic d, input logic p);
        cycle(1'b1, 1'b0);
        chk(nm, 32'({port_valid_b, port_out_b, pkt_done_b, err_trunc_b, pop_b_v}),
            32'({v, o, d, 1'b0, p}));
    endtask

    initial begin
        logic [7:0] w;
        int         cyc;
        int         n;
        rst = 1'b1; port_rd = 1'b0; port_addr = 8'h03;
        fifo_data = 8'h00; fifo_empty = 1'b1; fifo_data_b = 8'h00; fifo_empty_b = 1'b1;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("reset_state", 32'({port_valid, port_out, pkt_done, err_trunc, busy, rd_en,
                                port_valid_b, busy_b}), 32'd0);
        rst = 1'b0;
        model_en = 1'b1;

        // Basic frame
        start_pkt(); add_word(8'hAA, 1'b0); add_word(8'hBB, 1'b0); end_pkt(1'b0);
        n_pops = 0;
        dcyc("basic_c0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("basic_busy", 32'(busy), 32'd1);
        dcyc("basic_c1", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        dcyc("basic_c2", 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        dcyc("basic_c3", 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        dcyc("basic_c4", 1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        dcyc("basic_c5", 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        dcyc("basic_c6", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("basic_pops", 32'(n_pops), 32'd3);

        // Downstream backpressure after the address
        start_pkt(); add_word(8'hAA, 1'b0); add_word(8'hBB, 1'b0); end_pkt(1'b0);
        dcyc("bp_c0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dcyc("bp_c1", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        dcyc("bp_c2", 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        dcyc("bp_c3", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dcyc("bp_c4", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dcyc("bp_c5", 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        dcyc("bp_c6", 1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        dcyc("bp_c7", 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        dcyc("bp_c8", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // FIFO empty for three cycles mid-packet
        start_pkt(); add_word(8'hAA, 1'b0); add_word(8'hBB, 1'b0); end_pkt(1'b0);
        dcyc("empty_c0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dcyc("empty_c1", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        dcyc("empty_c2", 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        dcyc("empty_c3", 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        dcyc("empty_c4", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dcyc("empty_c5", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dcyc("empty_c6", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("empty_busy", 32'(busy), 32'd1);
        dcyc("empty_c7", 1'b1, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        dcyc("empty_c8", 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        dcyc("empty_c9", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Truncation at MAXL=4; drain pops continue with port_rd low
        start_pkt();
        for (int i = 1; i <= 6; i++) add_word(8'(i), 1'b0);
        end_pkt(1'b0);
        dcyc("trunc_c0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dcyc("trunc_c1", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        dcyc("trunc_c2", 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        dcyc("trunc_c3", 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        dcyc("trunc_c4", 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        dcyc("trunc_c5", 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
        dcyc("trunc_c6", 1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1);
        dcyc("trunc_c7", 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        dcyc("trunc_c8", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        dcyc("trunc_c9", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        dcyc("trunc_c10", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        dcyc("trunc_c11", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("trunc_end", 32'({fifo_q.size() == 0, busy}), 32'({1'b1, 1'b0}));

        // Back-to-back packets on the address-less instance
        fifo_b.push_back(8'hAA); fifo_b.push_back(8'h55);
        fifo_b.push_back(8'hCC); fifo_b.push_back(8'h55);
        bcyc("b2b_c0", 1'b0, 8'h00, 1'b0, 1'b0);
        bcyc("b2b_c1", 1'b1, 8'hFF, 1'b0, 1'b0);
        bcyc("b2b_c2", 1'b1, 8'hAA, 1'b0, 1'b1);
        bcyc("b2b_c3", 1'b1, 8'h55, 1'b1, 1'b1);
        bcyc("b2b_c4", 1'b0, 8'h00, 1'b0, 1'b0);
        bcyc("b2b_c5", 1'b1, 8'hFF, 1'b0, 1'b0);
        bcyc("b2b_c6", 1'b1, 8'hCC, 1'b0, 1'b1);
        bcyc("b2b_c7", 1'b1, 8'h55, 1'b1, 1'b1);
        bcyc("b2b_c8", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("b2b_pops", 32'(n_pops_b), 32'd4);

        // Reset mid-packet: frame abandoned, FIFO left as is
        model_en = 1'b0;
        put('{w: 8'hAA, drop: 1'b0}, 1'b0); put('{w: 8'hBB, drop: 1'b0}, 1'b0);
        put('{w: 8'hCC, drop: 1'b0}, 1'b0); put('{w: 8'hDD, drop: 1'b0}, 1'b0);
        put('{w: DELIM, drop: 1'b0}, 1'b0);
        dcyc("rst_c0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dcyc("rst_c1", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        dcyc("rst_c2", 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        dcyc("rst_c3", 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        dcyc("rst_c4", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_kept", 32'({fifo_q.size() == 4, fifo_q[0].w}), 32'({1'b1, 8'hBB}));
        fifo_q.delete();
        exp_q.delete();
        cycle(1'b1, 1'b0);
        rst = 1'b0;
        model_en = 1'b1;

        // Randomized traffic against the stream model
        port_addr = 8'h3C;
        for (int p = 0; p < 60; p++) begin
            start_pkt();
            n = int'($urandom_range(0, 7));
            for (int i = 0; i < n; i++) begin
                do w = 8'($urandom_range(0, 255)); while (w == DELIM);
                add_word(w, 1'b1);
            end
            end_pkt(1'b1);
        end
        cyc = 0;
        while (!(src_q.size() == 0 && fifo_q.size() == 0 && exp_q.size() == 0 && !busy)
               && cyc < 20000) begin
            if (src_q.size() != 0 && $urandom_range(0, 3) != 0) fifo_q.push_back(src_q.pop_front());
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            cyc++;
        end
        chk("random_budget", 32'(cyc < 20000), 32'd1);
        chk("random_drained", 32'({exp_q.size() == 0, fifo_q.size() == 0, busy}),
            32'({1'b1, 1'b1, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
